// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//   N-channel cacheline memory arbiter. Sits between NUM_CH cache pmem ports
//   and a single cacheline adaptor, granting one whole-line read or write at a
//   time in round-robin (RR_MODE=1) or fixed lowest-index-first (RR_MODE=0)
//   order. The winner's operation, address and write line are latched for the
//   whole transaction, so requester inputs are ignored once a grant is made.
//
// Ports
//   clk          in   1              rising-edge clock
//   reset_n      in   1              asynchronous active-low reset
//   ch_read      in   NUM_CH         per-channel line-read request (level)
//   ch_write     in   NUM_CH         per-channel line-write request (level)
//   ch_address   in   NUM_CH*ADDR_W  per-channel line address
//   ch_wdata     in   NUM_CH*LINE_W  per-channel write line
//   ch_rdata     out  LINE_W         returned read line (valid with ch_resp)
//   ch_resp      out  NUM_CH         one-hot, one-cycle completion
//   mem_read     out  1              read request to adaptor
//   mem_write    out  1              write request to adaptor
//   mem_address  out  ADDR_W         latched address of the granted request
//   mem_wdata    out  LINE_W         latched write line of the granted request
//   mem_rdata    in   LINE_W         line from adaptor, valid with mem_resp
//   mem_resp     in   1              adaptor completion pulse
//   gnt_id       out  CH_W           current / last granted channel
//   busy         out  1              transaction in flight (BUSY or DONE)
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_MODE = 1,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_resp,
    output logic [CH_W-1:0]            gnt_id,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     gnt_q, gnt_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic [NUM_CH-1:0]   req_s;
    logic [CH_W-1:0]     win_s;

    // Round-robin pick: lowest requester at or above ptr; if none, wrap to the
    // lowest requester overall. Descending scans leave the lowest hit last.
    function automatic logic [CH_W-1:0] pick_rr(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] hi_win;
        logic [CH_W-1:0] lo_win;
        logic            hi_found;
        hi_win   = '0;
        lo_win   = '0;
        hi_found = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                lo_win = CH_W'(c);
                if (c >= int'(ptr)) begin
                    hi_win   = CH_W'(c);
                    hi_found = 1'b1;
                end else begin
                    hi_win   = hi_win;
                end
            end else begin
                lo_win = lo_win;
            end
        end
        return hi_found ? hi_win : lo_win;
    endfunction

    // Fixed priority pick: lowest requesting index wins.
    function automatic logic [CH_W-1:0] pick_fixed(input logic [NUM_CH-1:0] req);
        logic [CH_W-1:0] win;
        win = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                win = CH_W'(c);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Request vector and winner selection for the IDLE cycle.
    always_comb begin
        req_s = ch_read | ch_write;
        if (RR_MODE != 0) begin
            win_s = pick_rr(req_s, rr_ptr_q);
        end else begin
            win_s = pick_fixed(req_s);
        end
    end

    // Next-state logic: grant in IDLE, wait for the adaptor in BUSY, respond in DONE.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (|req_s) begin
                    state_d = S_BUSY;
                    gnt_d   = win_s;
                    // Read+write on one channel is resolved as a write.
                    op_wr_d = ch_write[win_s];
                    addr_d  = ch_address[win_s*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[win_s*LINE_W +: LINE_W];
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (win_s == CH_W'(NUM_CH - 1)) ? '0 : win_s + CH_W'(1);
                    end else begin
                        rr_ptr_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Output decode from registered state only; nothing flows from ch_* to mem_*.
    always_comb begin
        ch_resp = '0;
        if (state_q == S_DONE) begin
            ch_resp[gnt_q] = 1'b1;
        end else begin
            ch_resp = '0;
        end
        mem_read    = (state_q == S_BUSY) & ~op_wr_q;
        mem_write   = (state_q == S_BUSY) &  op_wr_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        ch_rdata    = rdata_q;
        gnt_id      = gnt_q;
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//   Directed bench. Instance u_rr: NUM_CH=4, round-robin. Instance u_fp:
//   NUM_CH=2, fixed priority. Inputs are driven and outputs sampled 1 time
//   unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic [3:0]      a_rd, a_wr, a_resp;
    logic [4*AW-1:0] a_addr;
    logic [4*LW-1:0] a_wdata;
    logic [LW-1:0]   a_rdata, a_mwdata, a_mrdata;
    logic            a_mrd, a_mwr, a_mresp, a_busy;
    logic [AW-1:0]   a_maddr;
    logic [1:0]      a_gnt;

    // Fixed-priority instance signals
    logic [1:0]      b_rd, b_wr, b_resp;
    logic [2*AW-1:0] b_addr;
    logic [2*LW-1:0] b_wdata;
    logic [LW-1:0]   b_rdata, b_mwdata, b_mrdata;
    logic            b_mrd, b_mwr, b_mresp, b_busy;
    logic [AW-1:0]   b_maddr;
    logic [0:0]      b_gnt;

    int checks   = 0;
    int failures = 0;

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .ch_read(a_rd), .ch_write(a_wr), .ch_address(a_addr), .ch_wdata(a_wdata),
        .ch_rdata(a_rdata), .ch_resp(a_resp),
        .mem_read(a_mrd), .mem_write(a_mwr), .mem_address(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata), .mem_resp(a_mresp),
        .gnt_id(a_gnt), .busy(a_busy)
    );

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .ch_read(b_rd), .ch_write(b_wr), .ch_address(b_addr), .ch_wdata(b_wdata),
        .ch_rdata(b_rdata), .ch_resp(b_resp),
        .mem_read(b_mrd), .mem_write(b_mwr), .mem_address(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(b_mrdata), .mem_resp(b_mresp),
        .gnt_id(b_gnt), .busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_a(input string tag);
        int n;
        n = 0;
        while (a_busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, LW'(a_busy), LW'(1'b1));
    endtask

    task automatic wait_busy_b(input string tag);
        int n;
        n = 0;
        while (b_busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, LW'(b_busy), LW'(1'b1));
    endtask

    int          exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  oh;
    logic [LW-1:0] line;
    logic [LW-1:0] wline;

    initial begin
        // ---------------- Reset with random inputs ----------------
        a_rd = 4'($urandom); a_wr = 4'($urandom); a_mresp = 1'($urandom);
        b_rd = 2'($urandom); b_wr = 2'($urandom); b_mresp = 1'($urandom);
        a_addr = {$urandom, $urandom, $urandom, $urandom};
        b_addr = {$urandom, $urandom};
        for (int i = 0; i < 32; i++) a_wdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) b_wdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) begin
            a_mrdata[i*32 +: 32] = $urandom;
            b_mrdata[i*32 +: 32] = $urandom;
        end
        step(); step(); step();
        chk("rst_a_mem_read",  LW'(a_mrd),  LW'(1'b0));
        chk("rst_a_mem_write", LW'(a_mwr),  LW'(1'b0));
        chk("rst_a_ch_resp",   LW'(a_resp), LW'(4'b0000));
        chk("rst_a_busy",      LW'(a_busy), LW'(1'b0));
        chk("rst_a_mem_addr",  LW'(a_maddr), LW'(32'h0));
        chk("rst_a_mem_wdata", a_mwdata, '0);
        chk("rst_a_ch_rdata",  a_rdata, '0);
        chk("rst_a_gnt",       LW'(a_gnt), LW'(2'd0));
        chk("rst_b_busy",      LW'(b_busy), LW'(1'b0));
        chk("rst_b_mem_rw",    LW'({b_mrd, b_mwr}), LW'(2'b00));

        a_rd = 4'b0; a_wr = 4'b0; a_mresp = 1'b0; a_addr = '0; a_wdata = '0; a_mrdata = '0;
        b_rd = 2'b0; b_wr = 2'b0; b_mresp = 1'b0; b_addr = '0; b_wdata = '0; b_mrdata = '0;
        reset_n = 1'b1;
        step();

        // ---------------- RR fairness: all four channels read ----------------
        for (int c = 0; c < 4; c++) a_addr[c*AW +: AW] = 32'h0000_2000 + 32'(c) * 32'h40;
        a_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_busy_a("rr_wait_busy");
            chk("rr_gnt",      LW'(a_gnt), LW'(exp_order[i]));
            chk("rr_mem_addr", LW'(a_maddr), LW'(32'h0000_2000 + 32'(exp_order[i]) * 32'h40));
            line = {8{32'hC0DE_0000 + 32'(i)}};
            a_mrdata = line;
            a_mresp  = 1'b1;
            step();
            a_mresp  = 1'b0;
            oh = 4'b0001 << exp_order[i];
            chk("rr_ch_resp", LW'(a_resp), LW'(oh));
            chk("rr_ch_rdata", a_rdata, line);
            a_rd = a_rd & ~oh;
            step();
            chk("rr_resp_one_cycle", LW'(a_resp), LW'(4'b0000));
            a_rd = a_rd | oh;
        end
        a_rd = 4'b0000;
        step();
        chk("rr_idle_after", LW'(a_busy), LW'(1'b0));

        // ---------------- Single read on ch1 ----------------
        a_addr[AW +: AW] = 32'h0000_1240;
        a_rd = 4'b0010;
        step();
        chk("rd_mem_read_t1", LW'(a_mrd), LW'(1'b1));
        chk("rd_mem_write",   LW'(a_mwr), LW'(1'b0));
        chk("rd_mem_addr",    LW'(a_maddr), LW'(32'h0000_1240));
        chk("rd_gnt",         LW'(a_gnt), LW'(2'd1));
        step(); step(); step();
        chk("rd_no_early_resp", LW'(a_resp), LW'(4'b0000));
        chk("rd_still_reading", LW'(a_mrd), LW'(1'b1));
        a_mrdata = {32{8'hA5}};
        a_mresp  = 1'b1;
        step();
        a_mresp  = 1'b0;
        chk("rd_ch_resp",  LW'(a_resp), LW'(4'b0010));
        chk("rd_ch_rdata", a_rdata, {32{8'hA5}});
        chk("rd_mem_read_done", LW'(a_mrd), LW'(1'b0));
        chk("rd_busy_done", LW'(a_busy), LW'(1'b1));
        a_rd = 4'b0000;
        step();
        chk("rd_resp_clear", LW'(a_resp), LW'(4'b0000));
        chk("rd_busy_clear", LW'(a_busy), LW'(1'b0));

        // ---------------- Write latching on ch0 ----------------
        wline = {8{32'hDEAD_BEEF}};
        a_addr[0 +: AW] = 32'h0000_0080;
        a_wdata[0 +: LW] = wline;
        a_wr = 4'b0001;
        step();
        chk("wr_mem_write", LW'(a_mwr), LW'(1'b1));
        chk("wr_mem_read",  LW'(a_mrd), LW'(1'b0));
        a_addr[0 +: AW] = 32'hFFFF_0000;
        a_wdata[0 +: LW] = ~wline;
        a_rd = 4'b0100;
        step(); step();
        chk("wr_addr_latched",  LW'(a_maddr), LW'(32'h0000_0080));
        chk("wr_wdata_latched", a_mwdata, wline);
        chk("wr_gnt", LW'(a_gnt), LW'(2'd0));
        a_mresp = 1'b1;
        step();
        a_mresp = 1'b0;
        chk("wr_ch_resp", LW'(a_resp), LW'(4'b0001));
        chk("wr_addr_at_resp", LW'(a_maddr), LW'(32'h0000_0080));
        a_wr = 4'b0000;
        a_rd = 4'b0000;
        step();

        // ---------------- Stray mem_resp in IDLE ----------------
        a_mresp = 1'b1;
        step();
        a_mresp = 1'b0;
        chk("stray_no_resp", LW'(a_resp), LW'(4'b0000));
        chk("stray_no_busy", LW'(a_busy), LW'(1'b0));
        step();
        chk("stray_no_resp2", LW'(a_resp), LW'(4'b0000));

        // ---------------- Read+write on ch1 treated as write ----------------
        a_rd = 4'b0010;
        a_wr = 4'b0010;
        step();
        chk("rw_mem_write", LW'(a_mwr), LW'(1'b1));
        chk("rw_mem_read",  LW'(a_mrd), LW'(1'b0));
        chk("rw_gnt",       LW'(a_gnt), LW'(2'd1));
        a_mresp = 1'b1;
        step();
        a_mresp = 1'b0;
        chk("rw_ch_resp", LW'(a_resp), LW'(4'b0010));
        a_rd = 4'b0000;
        a_wr = 4'b0000;
        step();

        // ---------------- Request dropped before grant ----------------
        a_rd = 4'b0100;
        step();
        chk("drop_gnt2", LW'(a_gnt), LW'(2'd2));
        a_rd = 4'b1101;
        step();
        a_rd = 4'b0101;
        a_mresp = 1'b1;
        step();
        a_mresp = 1'b0;
        chk("drop_resp2", LW'(a_resp), LW'(4'b0100));
        a_rd = 4'b0001;
        step();
        wait_busy_a("drop_wait_busy");
        chk("drop_gnt_not3", LW'(a_gnt), LW'(2'd0));
        a_mresp = 1'b1;
        step();
        a_mresp = 1'b0;
        chk("drop_resp0", LW'(a_resp), LW'(4'b0001));
        a_rd = 4'b0000;
        step();

        // ---------------- Fixed priority (2 channels) ----------------
        b_addr = {32'h0000_0B00, 32'h0000_0A00};
        b_rd = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_busy_b("fp_wait_busy");
            chk("fp_gnt", LW'(b_gnt), (i < 3) ? LW'(1'b0) : LW'(1'b1));
            chk("fp_mem_addr", LW'(b_maddr), (i < 3) ? LW'(32'h0000_0A00) : LW'(32'h0000_0B00));
            b_mresp = 1'b1;
            step();
            b_mresp = 1'b0;
            chk("fp_ch_resp", LW'(b_resp), (i < 3) ? LW'(2'b01) : LW'(2'b10));
            b_rd = (i < 3) ? (b_rd & 2'b10) : 2'b00;
            step();
            if (i < 2) begin
                b_rd = b_rd | 2'b01;
            end
        end
        step();
        chk("fp_idle_after", LW'(b_busy), LW'(1'b0));

        // ---------------- Asynchronous reset mid-BUSY ----------------
        a_rd = 4'b0010;
        step();
        chk("mrst_mem_read_before", LW'(a_mrd), LW'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_mem_read_async", LW'(a_mrd), LW'(1'b0));
        chk("mrst_busy_async",     LW'(a_busy), LW'(1'b0));
        chk("mrst_addr_async",     LW'(a_maddr), LW'(32'h0));
        chk("mrst_gnt_async",      LW'(a_gnt), LW'(2'd0));
        chk("mrst_rdata_async",    a_rdata, '0);
        a_rd = 4'b0000;
        step();
        reset_n = 1'b1;
        step();
        chk("mrst_idle_after", LW'(a_busy), LW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
